// File: rtl/mdu_seq_ctrl_if.sv
// E-stage <-> MDU sequencer signal bundle: operation request, read select,
// D-stage hazard query, and the HI/LO/status results.
interface mdu_seq_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_sel;
    logic        d_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUO;
    logic        run_dbg;

    modport master (
        output start, op, A, B, rd_sel, d_md_use,
        input  busy, stall, HI, LO, MDUO, run_dbg
    );

    modport slave (
        input  start, op, A, B, rd_sel, d_md_use,
        output busy, stall, HI, LO, MDUO, run_dbg
    );
endinterface

// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO. The 64-bit result is
// computed at the start edge, held, and committed when the busy counter expires.
module mdu_seq_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input logic           clk,
    input logic           reset,
    mdu_seq_ctrl_if.slave bus
);
    // Request semantics: start qualifies op 1..4 and is accepted only in IDLE
    // (one edge, no acknowledge); mthi/mtlo need no start and act only in IDLE.
    // busy is the only completion indication; stall is the hazard-unit request.

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      hold_hi;
    logic [31:0]      hold_lo;
    logic             hold_ok;

    logic             is_md;
    logic             is_mult;
    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic [31:0]      div_a;
    logic [31:0]      div_b;
    logic [31:0]      uq;
    logic [31:0]      ur;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_ok;

    assign is_md   = bus.start && (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
    assign is_mult = (bus.op == OP_MULT) || (bus.op == OP_MULTU);

    assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // Signed divide runs on magnitudes; signs are restored afterwards, which
    // also yields 0x80000000 / -1 = 0x80000000 rem 0 without special casing.
    always_comb begin
        div_a  = ((bus.op == OP_DIV) && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
        div_b  = ((bus.op == OP_DIV) && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;
        uq     = '0;
        ur     = '0;
        if (div_b != 32'd0) begin
            uq = div_a / div_b;
            ur = div_a % div_b;
        end
    end

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_ok = 1'b1;
        case (bus.op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                res_ok = (div_b != 32'd0);
                res_lo = (bus.A[31] ^ bus.B[31]) ? (~uq + 32'd1) : uq;
                res_hi = bus.A[31] ? (~ur + 32'd1) : ur;
            end
            OP_DIVU: begin
                res_ok = (div_b != 32'd0);
                res_lo = uq;
                res_hi = ur;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (is_md) state_next = S_RUN;
            S_RUN:   if (cnt == CNT_W'(1)) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state == S_RUN);
        bus.run_dbg = (state == S_RUN);
        bus.stall   = bus.d_md_use && ((state == S_RUN) || is_md);
        bus.HI      = hi_q;
        bus.LO      = lo_q;
        bus.MDUO    = bus.rd_sel ? hi_q : lo_q;
    end

    // Divide by zero still runs the full latency but never commits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hold_hi <= '0;
            hold_lo <= '0;
            hold_ok <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_md) begin
                        cnt     <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        hold_hi <= res_hi;
                        hold_lo <= res_lo;
                        hold_ok <= res_ok;
                    end else if (bus.op == OP_MTHI) begin
                        hi_q <= bus.A;
                    end else if (bus.op == OP_MTLO) begin
                        lo_q <= bus.A;
                    end
                end
                S_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if ((cnt == CNT_W'(1)) && hold_ok) begin
                        hi_q <= hold_hi;
                        lo_q <= hold_lo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the E stage of the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from E and owns the HI/LO registers.
- Models operation latency with a busy counter and raises a stall request so D-stage MDU instructions wait.
- Supplies MDUO (the mfhi/mflo read value) that is carried into the M-stage pipeline register.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  E-stage instruction is mult/multu/div/divu; qualifies op
- op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  in  32  rs operand, forwarded
- B  in  32  rt operand, forwarded
- rd_sel  in  1  MDUO select: 0 LO, 1 HI
- d_md_use  in  1  D-stage instruction is any MDU instruction (mult/div/mf/mt)
- busy  out  1  operation in progress
- stall  out  1  stall request to the hazard unit
- HI  out  32  HI register
- LO  out  32  LO register
- MDUO  out  32  rd_sel ? HI : LO, combinational

Behaviour:
- Reset (async, any time, including mid-operation): HI=0, LO=0, busy=0, counter=0, pending result discarded.
  - Outputs after reset: stall=0, MDUO=0.
- States: IDLE (busy=0) and RUN (busy=1).
- IDLE, start=1, op in {1,2,3,4}:
  - At the edge, compute the 64-bit result from A/B into internal hold registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES; enter RUN. busy=1 from the next cycle.
- RUN: counter decrements each cycle.
  - On the edge where counter==1: HI/LO take the held result, busy drops, return to IDLE.
  - Total: busy high for exactly N cycles; new HI/LO visible on the cycle busy first reads 0.
- start with op 1-4 while busy=1: ignored. The hazard unit guarantees this cannot occur; the bench checks that it is ignored.
- mthi/mtlo (op 5/6, start not required):
  - In IDLE: write HI (or LO) := A at the edge.
  - In RUN: ignored.
- Arithmetic:
  - mult: signed 32x32 to 64, {HI,LO}.
  - multu: unsigned 32x32 to 64, {HI,LO}.
  - div: LO=quotient truncated toward zero; HI=remainder with the dividend's sign.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (div or divu): HI/LO unchanged at completion; busy still runs DIV_CYCLES.
- stall = d_md_use & (busy | (start & op in {1..4})). Combinational, so the instruction after a start sees the stall in the same cycle.
- MDUO is always the current register value. No HI/LO result bypass: a read during RUN returns the old value, and stall prevents this architecturally.
- Operands are sampled only at the start edge; later changes on A/B have no effect.

Test Plan:
- Reset mid-run:
  - Stimulus: mult A=3, B=4; assert reset asynchronously during cycle 2 of RUN.
  - Required: busy=0, HI=LO=0 immediately; no update after release.
- Signed mult:
  - Stimulus: mult A=0xFFFFFFFE (-2), B=3.
  - Required: busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Same operands as multu: HI=0x00000002, LO=0xFFFFFFFA.
- Signed and overflow divide:
  - div A=-7, B=2: after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero:
  - Stimulus: mtlo A=0x11, mthi A=0x22, then divu A=5, B=0.
  - Required: 10 busy cycles; HI=0x22, LO=0x11 retained.
- Stall generation:
  - Stimulus: start mult with d_md_use=1 in the same cycle.
  - Required: stall=1 that cycle and all 5 busy cycles, stall=0 after.
  - With d_md_use=0 throughout: stall=0 always.
- Ignored writes while RUN:
  - Stimulus: mthi A=0xDEAD and a second start div during RUN.
  - Required: both ignored; final HI/LO equal the first operation's result; busy length unchanged.
